// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg: shared definitions for the memory-transfer sequencer.
//   - xfer_state_e : sequencer states (IDLE, READ, DRAIN, DONE)
//   - AW_DEF       : default address width of memories A and B
//   - ALU_LAT_MAX  : largest supported ALU latency
//   - XFER_CNT_W   : width of the optional write counter (XFER_CNT_EN)
package mem_xfer_pkg;

   localparam int unsigned AW_DEF      = 4;
   localparam int unsigned ALU_LAT_MAX = 4;
   localparam int unsigned XFER_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } xfer_state_e;

endpackage

// File: rtl/xfer_dly.sv
// xfer_dly: strobe shift register used to align sequencer strobes with the
// memory A read latency and the ALU latency.
//   clock : rising-edge clock
//   flush : synchronous clear of every stage (abort/reset)
//   din   : strobe bits entering stage 0
//   taps  : all stages; taps[k] is din delayed by k+1 cycles
module xfer_dly #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2
) (
   input  logic                         clock,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             din,
   output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

   always_ff @(posedge clock) begin
      if (flush) begin
         taps <= '0;
      end else begin
         taps[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            taps[i] <= taps[i-1];
         end
      end
   end

endmodule

// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl: sequencer for the memory A -> ALU -> memory B transfer path.
// Issues memory A reads, tags operand pairs for the ALU and raises memory B
// write strobes aligned to the ALU latency. Holds no datapath.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   start, abort       : host handshake (start sampled in IDLE only)
//   len, src_base,
//   dst_base           : transfer descriptor, latched on an accepted start
//   rdA_en, rdA_addr   : memory A read strobe / address
//   alu_vld, alu_first : word at the ALU input / first word of a pair
//   wrB_en, wrB_addr   : memory B write strobe / address
//   busy, done         : status; done is a one-cycle completion pulse
//   xfer_cnt           : saturating count of wrB_en pulses (only with
//                        XFER_CNT_EN defined)
// ALU_LAT must lie in 1..ALU_LAT_MAX.
module mem_xfer_ctrl
   import mem_xfer_pkg::*;
#(
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [AW:0]           len,
   input  logic [AW-1:0]         src_base,
   input  logic [AW-1:0]         dst_base,
   output logic                  rdA_en,
   output logic [AW-1:0]         rdA_addr,
   output logic                  alu_vld,
   output logic                  alu_first,
   output logic                  wrB_en,
   output logic [AW-1:0]         wrB_addr,
   output logic                  busy,
   output logic                  done
`ifdef XFER_CNT_EN
   ,
   output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

   xfer_state_e   state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   rd_cnt_q, rd_cnt_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic          phase_q, phase_d;

   logic                    flush;
   logic                    pending;
   logic                    rd_last;
   logic [1:0]              dly_in;
   logic [ALU_LAT:0][1:0]   taps;   // bit 0: word valid, bit 1: write strobe

   assign rdA_en    = (state_q == ST_READ);
   assign alu_vld   = taps[0][0];
   assign alu_first = alu_vld & phase_q;
   assign wrB_en    = taps[ALU_LAT][1];
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign rdA_addr  = rdA_en ? (src_q + rd_cnt_q[AW-1:0]) : '0;
   assign wrB_addr  = wrB_en ? (dst_q + wr_cnt_q) : '0;

   // Odd-indexed reads are the second word of a pair and produce a write.
   assign dly_in  = {rdA_en & rd_cnt_q[0], rdA_en};
   assign flush   = reset | (abort & ((state_q == ST_READ) | (state_q == ST_DRAIN)));
   assign rd_last = (rd_cnt_q == (len_q - (AW+1)'(1)));

   xfer_dly #(
      .DEPTH (ALU_LAT + 1),
      .WIDTH (2)
   ) u_dly (
      .clock (clock),
      .flush (flush),
      .din   (dly_in),
      .taps  (taps)
   );

   // Tracking the valid bit (not just the write bit) keeps DRAIN alive for the
   // unpaired last word of an odd-length transfer. Stage ALU_LAT is the one
   // being output this cycle, so it never holds the FSM back.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < int'(ALU_LAT); i++) begin
         pending = pending | taps[i][0];
      end
   end

   logic unused_taps;
   assign unused_taps = ^taps;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wrB_en ? (wr_cnt_q + AW'(1)) : wr_cnt_q;
      phase_d  = alu_vld ? ~phase_q : phase_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d    = len;
               src_d    = src_base;
               dst_d    = dst_base;
               rd_cnt_d = '0;
               wr_cnt_d = '0;
               phase_d  = 1'b1;
               state_d  = (len == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            rd_cnt_d = rd_cnt_q + (AW+1)'(1);
            if (abort) begin
               state_d = ST_IDLE;
            end else if (rd_last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!pending) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         phase_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         phase_q  <= phase_d;
      end
   end

`ifdef XFER_CNT_EN
   logic [XFER_CNT_W-1:0] xfer_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         xfer_cnt_q <= '0;
      end else if (wrB_en && (xfer_cnt_q != '1)) begin
         xfer_cnt_q <= xfer_cnt_q + XFER_CNT_W'(1);
      end
   end

   assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl: directed transfers followed by random ones, each
// checked cycle by cycle against an expected timeline built from the transfer
// rules (read k at cycle 1+k, operand at 2+k, write of pair p at 3+2p+ALU_LAT).
module tb_mem_xfer_ctrl;

   localparam int AW  = 4;
   localparam int LAT = 1;
   localparam int NC  = 48;

   logic          clock = 1'b0;
   logic          reset, start, abort;
   logic [AW:0]   len;
   logic [AW-1:0] src_base, dst_base;
   logic          rdA_en, alu_vld, alu_first, wrB_en, busy, done;
   logic [AW-1:0] rdA_addr, wrB_addr;
`ifdef XFER_CNT_EN
   logic [15:0]   xfer_cnt;
`endif

   mem_xfer_ctrl #(
      .AW      (AW),
      .ALU_LAT (LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .len       (len),
      .src_base  (src_base),
      .dst_base  (dst_base),
      .rdA_en    (rdA_en),
      .rdA_addr  (rdA_addr),
      .alu_vld   (alu_vld),
      .alu_first (alu_first),
      .wrB_en    (wrB_en),
      .wrB_addr  (wrB_addr),
      .busy      (busy),
      .done      (done)
`ifdef XFER_CNT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   // Expected timeline, indexed by cycle relative to the start cycle (0).
   logic          e_rd   [NC];
   logic [AW-1:0] e_rda  [NC];
   logic          e_vld  [NC];
   logic          e_first[NC];
   logic          e_wr   [NC];
   logic [AW-1:0] e_wra  [NC];
   logic          e_busy [NC];
   logic          e_done [NC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns the cycle at which the DUT is back in IDLE.
   function automatic int build_model(input int ln, input int src, input int dst, input int ab);
      int dn;
      for (int c = 0; c < NC; c++) begin
         e_rd[c] = 0; e_rda[c] = '0; e_vld[c] = 0; e_first[c] = 0;
         e_wr[c] = 0; e_wra[c] = '0; e_busy[c] = 0; e_done[c] = 0;
      end
      if (ln == 0) begin
         dn = 1;
      end else begin
         for (int k = 0; k < ln; k++) begin
            e_rd[1+k]    = 1;
            e_rda[1+k]   = AW'(src + k);
            e_vld[2+k]   = 1;
            e_first[2+k] = ((k % 2) == 0);
            if ((k % 2) == 1) begin
               e_wr[2+k+LAT]  = 1;
               e_wra[2+k+LAT] = AW'(dst + k / 2);
            end
         end
         dn = ln + 2 + LAT;
      end
      e_done[dn] = 1;
      for (int c = 1; c <= dn; c++) e_busy[c] = 1;
      if (ab > 0) begin
         for (int c = ab + 1; c < NC; c++) begin
            e_rd[c] = 0; e_vld[c] = 0; e_first[c] = 0; e_wr[c] = 0;
            e_busy[c] = 0; e_done[c] = 0;
         end
         dn = ab;
      end
      for (int c = 0; c < NC; c++) if (e_wr[c]) exp_cnt++;
      if (exp_cnt > 65535) exp_cnt = 65535;
      return dn + 1;
   endfunction

   // Entered at the falling edge of an IDLE cycle; returns at the falling edge
   // of the first IDLE cycle after the transfer. ab > 0 aborts at that cycle.
   task automatic run(input int ln, input int src, input int dst, input int ab,
                      input bit noise, input string name);
      int last;
      last = build_model(ln, src, dst, ab);
      check($sformatf("%s c0 busy", name), busy, 0);
      check($sformatf("%s c0 rdA_en", name), rdA_en, 0);
      len      = (AW+1)'(ln);
      src_base = AW'(src);
      dst_base = AW'(dst);
      start    = 1'b1;
      abort    = noise ? 1'($urandom % 2) : 1'b0;  // ignored in IDLE
      for (int c = 1; c <= last; c++) begin
         @(negedge clock);
         check($sformatf("%s c%0d rdA_en", name, c), rdA_en, e_rd[c]);
         if (e_rd[c]) check($sformatf("%s c%0d rdA_addr", name, c), rdA_addr, e_rda[c]);
         check($sformatf("%s c%0d alu_vld", name, c), alu_vld, e_vld[c]);
         check($sformatf("%s c%0d alu_first", name, c), alu_first, e_first[c]);
         check($sformatf("%s c%0d wrB_en", name, c), wrB_en, e_wr[c]);
         if (e_wr[c]) check($sformatf("%s c%0d wrB_addr", name, c), wrB_addr, e_wra[c]);
         check($sformatf("%s c%0d busy", name, c), busy, e_busy[c]);
         check($sformatf("%s c%0d done", name, c), done, e_done[c]);
         // Mid-transfer start and descriptor changes must be ignored.
         start = noise && e_busy[c] && ($urandom % 2 == 1);
         if (noise && e_busy[c]) begin
            len      = (AW+1)'($urandom_range(0, 16));
            src_base = AW'($urandom);
            dst_base = AW'($urandom);
         end
         abort = (c == ab) || (noise && e_done[c]);  // abort in DONE is ignored
      end
      start = 1'b0;
      abort = 1'b0;
`ifdef XFER_CNT_EN
      check($sformatf("%s xfer_cnt", name), xfer_cnt, exp_cnt);
`endif
   endtask

   task automatic check_all_zero(input string name);
      check({name, " rdA_en"}, rdA_en, 0);
      check({name, " rdA_addr"}, rdA_addr, 0);
      check({name, " alu_vld"}, alu_vld, 0);
      check({name, " alu_first"}, alu_first, 0);
      check({name, " wrB_en"}, wrB_en, 0);
      check({name, " wrB_addr"}, wrB_addr, 0);
      check({name, " busy"}, busy, 0);
      check({name, " done"}, done, 0);
`ifdef XFER_CNT_EN
      check({name, " xfer_cnt"}, xfer_cnt, 0);
`endif
   endtask

   initial begin
      int ln, src, dst, ab;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      len = '0; src_base = '0; dst_base = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;
      exp_cnt = 0;
      @(negedge clock);

      run(4, 2, 9, -1, 1'b0, "basic");
      run(4, 14, 15, -1, 1'b0, "wrap");
      run(3, 5, 7, -1, 1'b0, "odd");
      run(0, 3, 3, -1, 1'b0, "zero");
      run(8, 1, 4, 3, 1'b0, "abort");
      @(negedge clock);
      run(6, 10, 12, -1, 1'b0, "post_abort");
      run(5, 0, 0, 7, 1'b0, "abort_drain");
      @(negedge clock);

      // Reset in the middle of a transfer clears everything, counter included.
      len = 5'd8; src_base = 4'd6; dst_base = 4'd2; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_all_zero("mid_reset");
      reset = 1'b0;
      exp_cnt = 0;
      @(negedge clock);

      // Two len=4 transfers with start pulses during busy: four writes total.
      run(4, 3, 8, -1, 1'b1, "cnt_a");
      run(4, 9, 1, -1, 1'b1, "cnt_b");
`ifdef XFER_CNT_EN
      check("cnt_two_xfers", xfer_cnt, 4);
`endif

      for (int i = 0; i < 14; i++) begin
         ln  = $urandom_range(0, 16);
         src = $urandom_range(0, 15);
         dst = $urandom_range(0, 15);
         ab  = -1;
         if (ln > 0 && ($urandom % 3 == 0)) ab = $urandom_range(1, ln + 1 + LAT);
         run(ln, src, dst, ab, 1'b1, $sformatf("rand%0d", i));
         if (ab > 0) @(negedge clock);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
